// File: rtl/hc_fifo_flex.sv
// Synchronous FIFO with first-word fall-through read, level flags and sticky error flags.
// Flags are decoded from the registered occupancy count only.
module hc_fifo_flex #(
    parameter int HC_FIFO_WIDTH  = 512,
    parameter int HC_FIFO_DEPTH  = 8,
    parameter int HC_FIFO_AFULL  = HC_FIFO_DEPTH - 2,
    parameter int HC_FIFO_AEMPTY = 2,
    localparam int CW = $clog2(HC_FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [HC_FIFO_WIDTH-1:0] enq_data,
    input  logic                     enq_en,
    output logic                     not_full,
    output logic [HC_FIFO_WIDTH-1:0] deq_data,
    input  logic                     deq_en,
    output logic                     not_empty,
    input  logic                     flush,
    input  logic                     err_clr,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [CW-1:0]            count,
    output logic [CW-1:0]            free,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(HC_FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(HC_FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(HC_FIFO_AFULL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(HC_FIFO_AEMPTY);

    logic [HC_FIFO_WIDTH-1:0] mem_q [HC_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          enq_ok, deq_ok, ovf_set, unf_set;

    assign not_full     = (count_q < DEPTH_C);
    assign not_empty    = (count_q != '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign free         = DEPTH_C - count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign deq_data     = mem_q[rd_ptr_q];

    always_comb begin
        deq_ok      = deq_en && not_empty && !flush;
        // A full FIFO still accepts a write when a read frees a slot in the same cycle.
        enq_ok      = enq_en && !flush && (not_full || deq_ok);
        ovf_set     = enq_en && !flush && !not_full && !deq_ok;
        unf_set     = deq_en && !flush && !not_empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (deq_ok) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({enq_ok, deq_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Set conditions win over a same-cycle clear.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_set) overflow_d  = 1'b1;
        if (unf_set) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (enq_ok) mem_q[wr_ptr_q] <= enq_data;
    end

endmodule

// File: tb/tb_hc_fifo_flex.sv
// Directed self-checking bench for hc_fifo_flex (WIDTH=16, DEPTH=8, AFULL=6, AEMPTY=2).
module tb_hc_fifo_flex;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  enq_data = '0;
    logic          enq_en = 1'b0;
    logic          deq_en = 1'b0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic          not_full, not_empty, almost_full, almost_empty, overflow, underflow;
    logic [W-1:0]  deq_data;
    logic [CW-1:0] count, free;

    int passed = 0;
    int total  = 0;

    hc_fifo_flex #(
        .HC_FIFO_WIDTH (W),
        .HC_FIFO_DEPTH (D),
        .HC_FIFO_AFULL (6),
        .HC_FIFO_AEMPTY(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enq_data    (enq_data),
        .enq_en      (enq_en),
        .not_full    (not_full),
        .deq_data    (deq_data),
        .deq_en      (deq_en),
        .not_empty   (not_empty),
        .flush       (flush),
        .err_clr     (err_clr),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .free        (free),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the currently driven inputs; sample 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enq_en = 1'b0; deq_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] v);
        enq_data = v; enq_en = 1'b1; deq_en = 1'b0;
        cyc();
        idle();
    endtask

    task automatic pop();
        deq_en = 1'b1; enq_en = 1'b0;
        cyc();
        idle();
    endtask

    initial begin
        // Reset state, observed while reset is held
        reset = 1'b1;
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_not_full", 32'(not_full), 1);
        chk("rst_not_empty", 32'(not_empty), 0);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_almost_empty", 32'(almost_empty), 1);
        chk("rst_free", 32'(free), 8);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_underflow", 32'(underflow), 0);
        cyc();
        reset = 1'b0;
        cyc();

        // Fill with 1..8; head stays at first word
        for (int i = 1; i <= 8; i++) begin
            push(W'(i));
            $display("enq 0x%04h count=%0d", i, count);
            chk("fill_count", 32'(count), 32'(i));
            chk("fill_almost_full", 32'(almost_full), (i >= 6) ? 1 : 0);
            chk("fill_almost_empty", 32'(almost_empty), (i <= 2) ? 1 : 0);
            chk("fill_head", 32'(deq_data), 1);
        end
        chk("full_not_full", 32'(not_full), 0);
        chk("full_free", 32'(free), 0);
        chk("full_not_empty", 32'(not_empty), 1);

        // Simultaneous enq/deq while full
        enq_data = 16'h00AA; enq_en = 1'b1; deq_en = 1'b1;
        cyc();
        idle();
        $display("full enq+deq count=%0d overflow=%0d", count, overflow);
        chk("fullsim_count", 32'(count), 8);
        chk("fullsim_overflow", 32'(overflow), 0);
        chk("fullsim_head", 32'(deq_data), 2);

        // Drain: 2..8 then 0xAA last
        for (int i = 2; i <= 9; i++) begin
            chk("drain_data", 32'(deq_data), (i == 9) ? 32'h00AA : 32'(i));
            $display("deq 0x%04h", deq_data);
            pop();
        end
        chk("drain_count", 32'(count), 0);
        chk("drain_not_empty", 32'(not_empty), 0);
        chk("drain_underflow", 32'(underflow), 0);

        // Simultaneous enq/deq while empty: deq rejected
        enq_data = 16'h0055; enq_en = 1'b1; deq_en = 1'b1;
        cyc();
        idle();
        $display("empty enq+deq count=%0d underflow=%0d", count, underflow);
        chk("emptysim_underflow", 32'(underflow), 1);
        chk("emptysim_count", 32'(count), 1);
        chk("emptysim_data", 32'(deq_data), 32'h0055);
        chk("emptysim_overflow", 32'(overflow), 0);
        err_clr = 1'b1;
        cyc();
        idle();
        chk("unf_clear", 32'(underflow), 0);

        // Fill to full, then overflow and its clearing rules
        for (int i = 0; i < 7; i++) push(W'(16'h0010 + i));
        chk("refill_count", 32'(count), 8);
        push(16'h0099);
        $display("enq on full count=%0d overflow=%0d", count, overflow);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_head", 32'(deq_data), 32'h0055);
        err_clr = 1'b1;
        cyc();
        idle();
        chk("ovf_clear", 32'(overflow), 0);
        err_clr = 1'b1; enq_data = 16'h0098; enq_en = 1'b1;
        cyc();
        idle();
        chk("ovf_set_beats_clr", 32'(overflow), 1);
        chk("ovf_clr_count", 32'(count), 8);
        err_clr = 1'b1;
        cyc();
        idle();
        chk("ovf_clear2", 32'(overflow), 0);

        // Rejected enq left memory alone: head sequence 0x55, 0x10, 0x11
        chk("pop_55", 32'(deq_data), 32'h0055);
        pop();
        chk("pop_10", 32'(deq_data), 32'h0010);
        pop();
        chk("pop_11", 32'(deq_data), 32'h0011);
        pop();
        chk("preflush_count", 32'(count), 5);

        // Flush with enq/deq requests present
        flush = 1'b1; enq_en = 1'b1; deq_en = 1'b1; enq_data = 16'h00EE;
        cyc();
        idle();
        $display("flush count=%0d not_empty=%0d", count, not_empty);
        chk("flush_count", 32'(count), 0);
        chk("flush_not_empty", 32'(not_empty), 0);
        chk("flush_almost_empty", 32'(almost_empty), 1);
        chk("flush_free", 32'(free), 8);
        chk("flush_overflow", 32'(overflow), 0);
        chk("flush_underflow", 32'(underflow), 0);

        // Asynchronous reset mid-cycle at count=4
        for (int i = 0; i < 4; i++) push(W'(16'h0021 + i));
        chk("prerst_count", 32'(count), 4);
        chk("prerst_head", 32'(deq_data), 32'h0021);
        #2;
        reset = 1'b1;
        #1;
        $display("async reset count=%0d free=%0d", count, free);
        chk("arst_count", 32'(count), 0);
        chk("arst_not_empty", 32'(not_empty), 0);
        chk("arst_free", 32'(free), 8);
        #1;
        reset = 1'b0;
        cyc();

        // One-cycle latency after reset
        push(16'h0077);
        $display("enq 0x0077 count=%0d deq_data=0x%04h", count, deq_data);
        chk("post_rst_not_empty", 32'(not_empty), 1);
        chk("post_rst_data", 32'(deq_data), 32'h0077);
        chk("post_rst_count", 32'(count), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
